// File: rtl/mvm_job_sequencer.sv
// mvm_job_sequencer: runs one matrix-vector job on an mvm core from a word stream and buffers the K results
module mvm_job_sequencer #(
   parameter int K       = 8,
   parameter int B       = 8,
   parameter int OW      = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [B-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [OW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   input  logic          abort,
   output logic          busy,
   output logic          err_underrun,
   output logic          err_timeout,
   output logic          mvm_reset,
   output logic          mvm_loadMatrix,
   output logic          mvm_loadVector,
   output logic          mvm_start,
   input  logic          mvm_done,
   output logic [B-1:0]  mvm_data_in,
   input  logic [OW-1:0] mvm_data_out
);
   localparam int CW = $clog2(K*K+1);
   localparam int TW = $clog2(TIMEOUT+1);
   localparam int PW = (K > 1) ? $clog2(K) : 1;
   localparam int NW = $clog2(K+1);

   typedef enum logic [3:0] {
      IDLE, CRST, LDM_HDR, LDM, LDV_HDR, LDV, GAP, START, WAIT, COLLECT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          err_underrun_q, err_underrun_d;
   logic          err_timeout_q, err_timeout_d;
   logic          mvm_reset_q, mvm_reset_d;
   logic [B-1:0]  mvm_data_in_q, mvm_data_in_d;
   logic [OW:0]   mem_q [K];
   logic [OW:0]   mem_d [K];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [NW-1:0] fill_q, fill_d;
   logic          loading, is_mat, push, push_last, pop, flush;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(K-1)) ? '0 : p + 1'b1;
   endfunction

   assign loading        = state_q inside {LDM_HDR, LDM, LDV_HDR, LDV};
   assign is_mat         = state_q inside {LDM_HDR, LDM};
   assign in_ready       = loading & ~abort;
   assign busy           = state_q != IDLE;
   assign mvm_loadMatrix = state_q == LDM_HDR;
   assign mvm_loadVector = state_q == LDV_HDR;
   assign mvm_start      = (state_q == START) & (fill_q == '0) & ~abort;
   assign mvm_reset      = mvm_reset_q;
   assign mvm_data_in    = mvm_data_in_q;
   assign err_underrun   = err_underrun_q;
   assign err_timeout    = err_timeout_q;
   assign out_valid      = fill_q != '0;
   assign out_data       = mem_q[rd_q][OW-1:0];
   assign out_last       = mem_q[rd_q][OW];
   assign pop            = out_valid & out_ready;

   // job sequencing: next state, counters, error flags and core strobes; abort overrides everything
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      timer_d        = timer_q;
      err_underrun_d = err_underrun_q;
      err_timeout_d  = err_timeout_q;
      mvm_reset_d    = 1'b0;
      mvm_data_in_d  = (in_ready & in_valid) ? in_data : '0;
      push           = 1'b0;
      push_last      = 1'b0;
      flush          = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d     = CRST;
               mvm_reset_d = 1'b1;
            end
         end
         CRST: state_d = LDM_HDR;
         LDM_HDR, LDM, LDV_HDR, LDV: begin
            if (!in_valid) begin
               err_underrun_d = 1'b1;
               mvm_reset_d    = 1'b1;
               state_d        = IDLE;
               cnt_d          = '0;
            end else if (cnt_q == CW'(is_mat ? K*K-1 : K-1)) begin
               cnt_d   = '0;
               state_d = is_mat ? LDV_HDR : GAP;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = is_mat ? LDM : LDV;
            end
         end
         GAP: state_d = START;
         START: begin
            if (mvm_start) begin
               state_d = WAIT;
               timer_d = '0;
            end
         end
         WAIT: begin
            if (mvm_done) begin
               state_d = COLLECT;
               cnt_d   = '0;
            end else if (timer_q == TW'(TIMEOUT-1)) begin
               err_timeout_d = 1'b1;
               mvm_reset_d   = 1'b1;
               state_d       = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         COLLECT: begin
            push      = 1'b1;
            push_last = cnt_q == CW'(K-1);
            cnt_d     = push_last ? '0 : cnt_q + 1'b1;
            state_d   = push_last ? IDLE : COLLECT;
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d        = IDLE;
         cnt_d          = '0;
         timer_d        = '0;
         err_underrun_d = 1'b0;
         err_timeout_d  = 1'b0;
         mvm_reset_d    = 1'b1;
         mvm_data_in_d  = '0;
         push           = 1'b0;
         flush          = 1'b1;
      end
   end

   // result FIFO: circular buffer with fill count; the entry's top bit marks y[K-1]
   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      fill_d = fill_q;
      if (flush) begin
         wr_d   = '0;
         rd_d   = '0;
         fill_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = {push_last, mvm_data_out};
            wr_d        = wrap_inc(wr_q);
         end
         if (pop) rd_d = wrap_inc(rd_q);
         fill_d = fill_q + NW'(push) - NW'(pop);
      end
   end

   // state register for the sequencer and the FIFO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         timer_q        <= '0;
         err_underrun_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         mvm_reset_q    <= 1'b0;
         mvm_data_in_q  <= '0;
         mem_q          <= '{default: '0};
         wr_q           <= '0;
         rd_q           <= '0;
         fill_q         <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         timer_q        <= timer_d;
         err_underrun_q <= err_underrun_d;
         err_timeout_q  <= err_timeout_d;
         mvm_reset_q    <= mvm_reset_d;
         mvm_data_in_q  <= mvm_data_in_d;
         mem_q          <= mem_d;
         wr_q           <= wr_d;
         rd_q           <= rd_d;
         fill_q         <= fill_d;
      end
   end
endmodule

// File: tb/tb_mvm_job_sequencer.sv
// tb_mvm_job_sequencer: scoreboard bench with a behavioural mvm core model
module tb_mvm_job_sequencer;
   localparam int K       = 8;
   localparam int B       = 8;
   localparam int OW      = 16;
   localparam int TIMEOUT = 16;
   localparam int LAT     = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [B-1:0]  in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          abort = 1'b0;
   logic          busy;
   logic          err_underrun;
   logic          err_timeout;
   logic          mvm_reset;
   logic          mvm_loadMatrix;
   logic          mvm_loadVector;
   logic          mvm_start;
   logic          mvm_done = 1'b0;
   logic [B-1:0]  mvm_data_in;
   logic [OW-1:0] mvm_data_out = '0;

   mvm_job_sequencer #(.K(K), .B(B), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .abort(abort), .busy(busy), .err_underrun(err_underrun), .err_timeout(err_timeout),
      .mvm_reset(mvm_reset), .mvm_loadMatrix(mvm_loadMatrix), .mvm_loadVector(mvm_loadVector),
      .mvm_start(mvm_start), .mvm_done(mvm_done), .mvm_data_in(mvm_data_in),
      .mvm_data_out(mvm_data_out)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errs = 0;
   int           cyc = 0;
   int           starts = 0;
   int           start_cyc = 0;
   int           acc_cnt = 0;
   int           occ = 0;
   int           core_t = 0;
   int           col_i = 0;
   bit           col_active = 0;
   bit           core_cap = 0;
   bit           core_mode = 1;
   bit           hold = 0;
   bit           sink_en = 1;
   bit           abort_req = 0;
   logic [B-1:0] core_tag = '0;
   logic [B-1:0] din_next = '0;
   logic [B-1:0] src_q[$];
   logic [OW:0]  exp_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic submit(input logic [B-1:0] tag, input bit keep);
      src_q.push_back(tag);
      for (int n = 1; n < K*K+K; n++) src_q.push_back(B'($urandom_range(0, 255)));
      if (keep) for (int i = 0; i < K; i++) exp_q.push_back({i == K-1, OW'(tag) + OW'(i)});
   endtask

   // one clock: drive at the falling edge, sample 1 time unit later, update models
   task automatic cycle();
      logic [OW:0] e;
      @(negedge clk);
      mvm_done     = core_mode && (core_t == 1);
      mvm_data_out = col_active ? OW'(core_tag) + OW'(col_i) : '0;
      in_valid     = !hold && (src_q.size() != 0);
      in_data      = in_valid ? src_q[0] : '0;
      out_ready    = sink_en;
      abort        = abort_req;
      #1;
      cyc++;
      check("din", mvm_data_in, din_next);
      check("ovalid", out_valid, occ != 0);
      if (core_cap) begin
         core_tag = mvm_data_in;
         core_cap = 0;
      end
      if (mvm_loadMatrix) begin
         check("ldm_at", acc_cnt, 0);
         core_cap = 1;
      end
      if (mvm_loadVector) check("ldv_at", acc_cnt, K*K);
      if (mvm_start) begin
         starts++;
         start_cyc = cyc;
         check("start_empty", occ, 0);
      end
      din_next = '0;
      if (in_ready && in_valid) begin
         din_next = in_data;
         void'(src_q.pop_front());
         acc_cnt++;
         if (acc_cnt == K*K+K) acc_cnt = 0;
      end
      if (!busy) acc_cnt = 0;
      if (out_valid && out_ready) begin
         occ--;
         if (exp_q.size() == 0) check("spurious_out", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[OW-1:0]);
            check("out_last", out_last, e[OW]);
         end
      end
      if (col_active && !abort) occ++;
      if (abort) occ = 0;
      if (col_active) begin
         col_i++;
         if (col_i == K) col_active = 0;
      end
      if (core_t > 0) core_t--;
      if (mvm_done) begin
         col_active = 1;
         col_i = 0;
      end
      if (mvm_start && core_mode) core_t = LAT;
      if (mvm_reset || abort) begin
         core_t = 0;
         col_active = 0;
         core_cap = 0;
      end
   endtask

   task automatic run_done(input string tag);
      int n = 0;
      while (n < 2000 && (exp_q.size() != 0 || src_q.size() != 0 || busy)) begin
         cycle();
         n++;
      end
      check(tag, n < 2000, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int s0;
      repeat (3) cycle();
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_err_u", err_underrun, 0);
      check("rst_err_t", err_timeout, 0);
      check("rst_mvm_reset", mvm_reset, 0);
      check("rst_ldm", mvm_loadMatrix, 0);
      check("rst_ldv", mvm_loadVector, 0);
      check("rst_start", mvm_start, 0);
      check("rst_din", mvm_data_in, 0);
      reset = 1'b1;
      repeat (2) cycle();

      // single job: results 100..107
      submit(8'd100, 1);
      cycle();
      check("t1_idle_cycle", busy, 0);
      cycle();
      check("t1_crst_reset", mvm_reset, 1);
      check("t1_crst_ready", in_ready, 0);
      cycle();
      check("t1_ldm_pulse", mvm_loadMatrix, 1);
      check("t1_ldm_ready", in_ready, 1);
      run_done("t1_done");
      check("t1_starts", starts, 1);
      check("t1_busy_after", busy, 0);

      // back-to-back jobs with a stalled sink: job 2 waits in START
      sink_en = 0;
      s0 = starts;
      submit(8'd110, 1);
      submit(8'd120, 1);
      n = 0;
      while (n < 400 && src_q.size() != 0) begin
         cycle();
         n++;
      end
      check("t2_load_bound", n < 400, 1);
      repeat (6) cycle();
      check("t2_stalled_starts", starts - s0, 1);
      check("t2_stalled_busy", busy, 1);
      check("t2_stalled_start", mvm_start, 0);
      sink_en = 1;
      run_done("t2_done");
      check("t2_starts", starts - s0, 2);

      // underrun at matrix word 30, then a clean restart
      submit(8'd33, 0);
      n = 0;
      while (n < 200 && acc_cnt < 30) begin
         cycle();
         n++;
      end
      check("t3_reach30", acc_cnt, 30);
      hold = 1;
      cycle();
      cycle();
      check("t3_err_u", err_underrun, 1);
      check("t3_mvm_reset", mvm_reset, 1);
      check("t3_in_ready", in_ready, 0);
      check("t3_busy", busy, 0);
      src_q.delete();
      hold = 0;
      cycle();
      check("t3_reset_once", mvm_reset, 0);
      submit(8'd40, 1);
      run_done("t3_restart_done");
      check("t3_err_u_sticky", err_underrun, 1);

      // core never signals done: timeout
      core_mode = 0;
      s0 = starts;
      submit(8'd44, 0);
      n = 0;
      while (n < 300 && starts == s0) begin
         cycle();
         n++;
      end
      check("t4_started", starts - s0, 1);
      n = 0;
      while (n < 100 && !err_timeout) begin
         cycle();
         n++;
      end
      check("t4_delay", cyc - start_cyc, TIMEOUT+1);
      check("t4_mvm_reset", mvm_reset, 1);
      check("t4_busy", busy, 0);
      core_mode = 1;
      cycle();
      check("t4_reset_once", mvm_reset, 0);

      // abort during COLLECT after 3 pushes
      sink_en = 0;
      submit(8'd50, 0);
      n = 0;
      while (n < 300 && !(col_active && col_i == 3)) begin
         cycle();
         n++;
      end
      check("t5_pre_valid", out_valid, 1);
      check("t5_pre_err_t", err_timeout, 1);
      abort_req = 1;
      cycle();
      abort_req = 0;
      cycle();
      check("t5_out_valid", out_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_err_u", err_underrun, 0);
      check("t5_err_t", err_timeout, 0);
      check("t5_mvm_reset", mvm_reset, 1);
      cycle();
      check("t5_reset_once", mvm_reset, 0);
      sink_en = 1;

      // asynchronous reset in the middle of the vector load
      submit(8'd60, 0);
      n = 0;
      while (n < 300 && acc_cnt != K*K+3) begin
         cycle();
         n++;
      end
      check("t6_reach_ldv", acc_cnt, K*K+3);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_in_ready", in_ready, 0);
      check("t6_din", mvm_data_in, 0);
      check("t6_mvm_reset", mvm_reset, 0);
      check("t6_out_valid", out_valid, 0);
      src_q.delete();
      occ = 0;
      din_next = '0;
      core_t = 0;
      col_active = 0;
      core_cap = 0;
      acc_cnt = 0;
      repeat (3) cycle();
      reset = 1'b1;
      submit(8'd70, 1);
      run_done("t6_done");
      check("t6_err_u", err_underrun, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
